// File: rtl/imem_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit instruction-memory writes (5 cycles/word min),
// stalls on in_valid low and holds cpu_reset until done; optional trailing XOR byte via LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int DEPTH     = 100,
   parameter int LEN_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [LEN_WIDTH-1:0] load_len_i,
   input  logic                 in_valid_i,
   input  logic [7:0]           in_data_i,
   output logic                 in_ready_o,
   output logic                 wr_en_o,
   output logic [31:0]          wr_addr_o,
   output logic [31:0]          wr_data_o,
   output logic                 cpu_reset_o,
   output logic                 done_o,
   output logic                 chk_err_o
);

   typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;

   localparam logic [29:0] DEPTH_W = 30'(DEPTH);

   state_t      state_q, state_d;
   logic [29:0] len_q, len_d;
   logic [29:0] word_idx_q, word_idx_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [31:0] shift_q, shift_d;
   logic        wr_en_q, wr_en_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic [29:0] len_req, len_clamp;

   assign len_req   = 30'(load_len_i);
   assign len_clamp = (len_req > DEPTH_W) ? DEPTH_W : len_req;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] chk_q, chk_d;
   logic       chk_err_q, chk_err_d;
`endif

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_idx_d = word_idx_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      in_ready_o = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_d      = chk_q;
      chk_err_d  = chk_err_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               len_d      = len_clamp;
               word_idx_d = '0;
               byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
               chk_d      = '0;
               chk_err_d  = 1'b0;
               state_d    = (len_clamp == '0) ? CHECK : RECV;
`else
               state_d    = (len_clamp == '0) ? DONE : RECV;
`endif
            end
         end
         RECV: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               shift_d    = {shift_q[23:0], in_data_i};
               byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
               chk_d      = chk_q ^ in_data_i;
`endif
               // Fourth byte completes the word; register the write strobe for the WRITE cycle.
               if (byte_cnt_q == 2'd3) begin
                  state_d   = WRITE;
                  wr_en_d   = 1'b1;
                  wr_addr_d = {word_idx_q, 2'b00};
                  wr_data_d = shift_d;
               end
            end
         end
         WRITE: begin
            word_idx_d = word_idx_q + 30'd1;
            if (word_idx_q == len_q - 30'd1) begin
`ifdef LOADER_CHECKSUM_EN
               state_d = CHECK;
`else
               state_d = DONE;
`endif
            end else begin
               state_d = RECV;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               chk_err_d = (in_data_i != chk_q);
               state_d   = DONE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         len_q      <= '0;
         word_idx_q <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
         chk_q      <= '0;
         chk_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_idx_q <= word_idx_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
`ifdef LOADER_CHECKSUM_EN
         chk_q      <= chk_d;
         chk_err_q  <= chk_err_d;
`endif
      end
   end

   assign wr_en_o   = wr_en_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_data_q;
   assign done_o    = (state_q == DONE);

`ifdef LOADER_CHECKSUM_EN
   // A bad checksum still finishes the load but never releases the core.
   assign cpu_reset_o = (state_q != DONE) | chk_err_q;
   assign chk_err_o   = chk_err_q;
`else
   assign cpu_reset_o = (state_q != DONE);
   assign chk_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: hand-computed writes, cycle timing, back-pressure, clamp, abort, checksum.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  load_len = '0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = '0;
   logic        in_ready, wr_en, cpu_reset, done, chk_err;
   logic [31:0] wr_addr, wr_data;

   int errors = 0;
   int checks = 0;

   logic [7:0]  stim [0:511];
   logic [31:0] wa [0:127];
   logic [31:0] wd [0:127];
   int          wc [0:127];
   int          nwr, done_cyc, rdy_bad, taken;

   imem_loader #(.DEPTH(100), .LEN_WIDTH(8)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .load_len_i(load_len),
      .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
      .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
      .cpu_reset_o(cpu_reset), .done_o(done), .chk_err_o(chk_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one edge; afterwards the bench sits in cycle 1 of the load.
   task automatic do_start(input logic [7:0] len);
      start = 1'b1;
      load_len = len;
      tick();
      start = 1'b0;
   endtask

   // Byte source: offers stim[k] while valid, advances k on each accepted transfer.
   // Records every write with its cycle index (cycle 1 = first cycle after the start edge).
   task automatic stream(input int nbytes, input bit toggle, input int budget);
      int k = 0;
      int c = 1;
      bit xfer;
      nwr = 0; done_cyc = -1; rdy_bad = 0;
      while (c <= budget && done_cyc < 0) begin
         if (wr_en) begin
            wa[nwr] = wr_addr; wd[nwr] = wr_data; wc[nwr] = c;
            nwr++;
            if (in_ready) rdy_bad++;
         end
         if (done) done_cyc = c;
         in_valid = (k < nbytes) && (toggle ? (c % 2 == 1) : 1'b1);
         in_data  = (k < nbytes) ? stim[k] : 8'h00;
         xfer = in_valid && in_ready;
         tick();
         if (xfer) k++;
         c++;
      end
      in_valid = 1'b0;
      taken = k;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"},  32'(in_ready),  32'd0);
      check({tag, "_wr_en"},     32'(wr_en),     32'd0);
      check({tag, "_wr_addr"},   wr_addr,        32'h0);
      check({tag, "_wr_data"},   wr_data,        32'h0);
      check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
      check({tag, "_done"},      32'(done),      32'd0);
      check({tag, "_chk_err"},   32'(chk_err),   32'd0);
   endtask

   initial begin
      // Reset
      tick(); tick();
      check_reset_vals("rst");
      rst = 1'b0;
      tick();
      check_reset_vals("idle");

      // Case 1: two words, in_valid held high
      stim[0] = 8'h20; stim[1] = 8'h08; stim[2] = 8'h00; stim[3] = 8'h05;
      stim[4] = 8'h8C; stim[5] = 8'h01; stim[6] = 8'h00; stim[7] = 8'h04;
      do_start(8'd2);
`ifdef LOADER_CHECKSUM_EN
      stim[8] = 8'h20 ^ 8'h08 ^ 8'h05 ^ 8'h8C ^ 8'h01 ^ 8'h04;
      stream(9, 1'b0, 40);
`else
      stream(8, 1'b0, 40);
`endif
      check("c1_nwr",   nwr,   2);
      check("c1_addr0", wa[0], 32'h0);
      check("c1_data0", wd[0], 32'h20080005);
      check("c1_cyc0",  wc[0], 5);
      check("c1_addr1", wa[1], 32'h4);
      check("c1_data1", wd[1], 32'h8C010004);
      check("c1_cyc1",  wc[1], 10);
`ifndef LOADER_CHECKSUM_EN
      check("c1_done_cyc", done_cyc, 11);
`endif
      check("c1_cpu_reset", 32'(cpu_reset), 32'd0);
      check("c1_chk_err",   32'(chk_err),   32'd0);
      in_valid = 1'b1;
      check("c1_done_ready", 32'(in_ready), 32'd0);
      tick();
      in_valid = 1'b0;
      check("c1_done_hold", 32'(done), 32'd1);

      // Case 2: in_valid toggles every cycle; restart from DONE
      do_start(8'd2);
      check("c2_restart_cpu_reset", 32'(cpu_reset), 32'd1);
      check("c2_restart_done",      32'(done),      32'd0);
`ifdef LOADER_CHECKSUM_EN
      stream(9, 1'b1, 60);
`else
      stream(8, 1'b1, 60);
`endif
      check("c2_nwr",   nwr,   2);
      check("c2_data0", wd[0], 32'h20080005);
      check("c2_data1", wd[1], 32'h8C010004);
      check("c2_addr1", wa[1], 32'h4);
      check("c2_rdy_on_write", rdy_bad, 0);
      check("c2_done",  32'(done), 32'd1);

`ifndef LOADER_CHECKSUM_EN
      // Case 3: zero-length load
      do_start(8'd0);
      stream(0, 1'b0, 2);
      check("c3_nwr", nwr, 0);
      check("c3_done_by_2", 32'(done_cyc >= 1 && done_cyc <= 2), 32'd1);
      check("c3_cpu_reset", 32'(cpu_reset), 32'd0);
`endif

      // Case 4: load_len beyond DEPTH is clamped to 100 words
      for (int i = 0; i < 512; i++) stim[i] = 8'(i) ^ 8'h5A;
`ifdef LOADER_CHECKSUM_EN
      begin
         logic [7:0] x = '0;
         for (int i = 0; i < 400; i++) x = x ^ stim[i];
         stim[400] = x;
      end
`endif
      do_start(8'd200);
      stream(404, 1'b0, 700);
      check("c4_nwr",       nwr,       100);
      check("c4_last_addr", wa[99],    32'h18C);
      check("c4_last_data", wd[99],    {8'(396) ^ 8'h5A, 8'(397) ^ 8'h5A, 8'(398) ^ 8'h5A, 8'(399) ^ 8'h5A});
`ifdef LOADER_CHECKSUM_EN
      check("c4_taken",     taken,     401);
`else
      check("c4_taken",     taken,     400);
      check("c4_done_cyc",  done_cyc,  501);
`endif
      check("c4_done",      32'(done), 32'd1);

      // Case 5: reset after two bytes of the first word
      stim[0] = 8'h11; stim[1] = 8'h22;
      do_start(8'd1);
      stream(2, 1'b0, 3);
      check("c5_partial_nwr", nwr, 0);
      rst = 1'b1;
      tick();
      check("c5_wr_en_in_rst", 32'(wr_en), 32'd0);
      rst = 1'b0;
      tick();
      check_reset_vals("c5");
      stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC; stim[3] = 8'hDD;
      stim[4] = 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD;
      do_start(8'd1);
`ifdef LOADER_CHECKSUM_EN
      stream(5, 1'b0, 20);
`else
      stream(4, 1'b0, 20);
`endif
      check("c5_nwr",  nwr,   1);
      check("c5_addr", wa[0], 32'h0);
      check("c5_data", wd[0], 32'hAABBCCDD);
      check("c5_cyc",  wc[0], 5);

`ifdef LOADER_CHECKSUM_EN
      // Case 6: checksum good then bad
      stim[0] = 8'h01; stim[1] = 8'h02; stim[2] = 8'h03; stim[3] = 8'h04; stim[4] = 8'h04;
      do_start(8'd1);
      stream(5, 1'b0, 20);
      check("c6_good_done",      32'(done),      32'd1);
      check("c6_good_chk_err",   32'(chk_err),   32'd0);
      check("c6_good_cpu_reset", 32'(cpu_reset), 32'd0);
      stim[4] = 8'h05;
      do_start(8'd1);
      check("c6_start_clears", 32'(chk_err), 32'd0);
      stream(5, 1'b0, 20);
      check("c6_bad_done",      32'(done),      32'd1);
      check("c6_bad_chk_err",   32'(chk_err),   32'd1);
      check("c6_bad_cpu_reset", 32'(cpu_reset), 32'd1);
      stim[0] = 8'h00;
      do_start(8'd0);
      stream(1, 1'b0, 5);
      check("c6_zero_nwr",     nwr,            0);
      check("c6_zero_chk_err", 32'(chk_err),   32'd0);
      check("c6_zero_reset",   32'(cpu_reset), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
